// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// MMIO window layout and the alignment rule.
// The memory-mapped register window is built only when DMEM_MMIO_EN is defined
// (it is undefined by default).
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  localparam logic [31:0] MMIO_BASE       = 32'hFFFF_FF00;
  localparam logic [3:0]  MMIO_OFF_CYCLE  = 4'h0;
  localparam logic [3:0]  MMIO_OFF_TOHOST = 4'h4;

  // A sub-word access into the MMIO window is treated like a misaligned one,
  // so the registers only ever see whole-word traffic.
  function automatic logic is_misaligned(size_e sz, logic [1:0] lane, logic mmio);
    logic mis;
    mis = 1'b0;
    case (sz)
      SZ_BYTE: mis = mmio;
      SZ_HALF: mis = lane[0] | mmio;
      SZ_WORD: mis = |lane;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: asynchronous read, synchronous byte-enabled write.
module dmem_ram #(
  parameter int    DEPTH_WORDS = 4096,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Commit only the enabled byte lanes of the addressed word.
  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder on the core's MEM-stage bus. Loads are combinational,
// stores commit on the clock edge with byte enables. Misaligned accesses are
// suppressed and recorded in sticky flags.
// Optional feature: define DMEM_MMIO_EN to map a CYCLE counter and a TOHOST
// mailbox (with HALT) at 0xFFFFFF00..0xFFFFFF0F.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS = 4096,
  parameter string INIT_FILE   = ""
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] ALU_VAL_EM,
  input  logic [31:0] STORE_VAL_EM,
  input  logic [1:0]  MemWrite_EM,
  input  logic [1:0]  MemRead_EM,
  input  logic        DMSE_EM,
  output logic [31:0] MEM_DATA_M,
  output logic        MISALIGN,
  output logic [31:0] ERR_ADDR,
  output logic        HALT,
  output logic [31:0] TOHOST
);

  localparam int AW = $clog2(DEPTH_WORDS);

  size_e         rd_sz;
  size_e         wr_sz;
  logic [1:0]    lane;
  logic [AW-1:0] widx;
  logic          mmio_hit;
  logic          mis_any;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   lane_data;
  logic [31:0]   load_raw;
  logic [31:0]   mmio_rdata;
  logic          misalign_q;
  logic [31:0]   err_addr_q;

  // Right-align already happened via the lane shift; widen to 32 bits.
  function automatic logic [31:0] extend_load(logic [31:0] raw, size_e sz, logic se);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = raw[7:0];
    h = raw[15:0];
    case (sz)
      SZ_BYTE: r = se ? 32'(b) : {24'h0, raw[7:0]};
      SZ_HALF: r = se ? 32'(h) : {16'h0, raw[15:0]};
      SZ_WORD: r = raw;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  assign rd_sz = size_e'(MemRead_EM);
  assign wr_sz = size_e'(MemWrite_EM);
  assign lane  = ALU_VAL_EM[1:0];
  assign widx  = ALU_VAL_EM[AW+1:2];

  assign mis_any = is_misaligned(rd_sz, lane, mmio_hit) |
                   is_misaligned(wr_sz, lane, mmio_hit);

  // Store lane placement: replicate the right-aligned data, enable only the target lanes.
  always_comb begin
    ram_be    = 4'h0;
    ram_wdata = STORE_VAL_EM;
    case (wr_sz)
      SZ_BYTE: begin
        ram_be    = 4'b0001 << lane;
        ram_wdata = {4{STORE_VAL_EM[7:0]}};
      end
      SZ_HALF: begin
        ram_be    = 4'b0011 << lane;
        ram_wdata = {2{STORE_VAL_EM[15:0]}};
      end
      SZ_WORD: ram_be = 4'hF;
      default: ram_be = 4'h0;
    endcase
  end

  // RSTN gates the write so an edge seen during reset never touches RAM.
  assign ram_we = (wr_sz != SZ_NONE) && !mis_any && !mmio_hit && RSTN;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .be    (ram_be),
    .waddr (widx),
    .wdata (ram_wdata),
    .raddr (widx),
    .rdata (ram_rdata)
  );

  // Load path: shift the addressed lane down, then extend; reads see the pre-store word.
  always_comb begin
    lane_data = ram_rdata >> {lane, 3'b000};
    load_raw  = mmio_hit ? mmio_rdata : lane_data;
    if (rd_sz == SZ_NONE || mis_any) MEM_DATA_M = 32'h0;
    else                             MEM_DATA_M = extend_load(load_raw, rd_sz, DMSE_EM);
  end

  // Sticky misalignment flag; only the first offending address is kept.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      misalign_q <= 1'b0;
      err_addr_q <= 32'h0;
    end else if (mis_any) begin
      misalign_q <= 1'b1;
      if (!misalign_q) err_addr_q <= ALU_VAL_EM;
    end
  end

  assign MISALIGN = misalign_q;
  assign ERR_ADDR = err_addr_q;

`ifdef DMEM_MMIO_EN
  logic [31:0] cycle_q;
  logic [31:0] tohost_q;
  logic        halt_q;
  logic        tohost_we;

  assign mmio_hit  = (ALU_VAL_EM[31:4] == MMIO_BASE[31:4]);
  assign tohost_we = mmio_hit && (wr_sz == SZ_WORD) && !mis_any &&
                     (ALU_VAL_EM[3:0] == MMIO_OFF_TOHOST);

  // Register read mux; unmapped offsets read as zero.
  always_comb begin
    mmio_rdata = 32'h0;
    case (ALU_VAL_EM[3:0])
      MMIO_OFF_CYCLE:  mmio_rdata = cycle_q;
      MMIO_OFF_TOHOST: mmio_rdata = tohost_q;
      default:         mmio_rdata = 32'h0;
    endcase
  end

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) cycle_q <= 32'h0;
    else       cycle_q <= cycle_q + 32'd1;
  end

  // TOHOST mailbox: a word store latches the value and raises a sticky HALT.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tohost_q <= 32'h0;
      halt_q   <= 1'b0;
    end else if (tohost_we) begin
      tohost_q <= STORE_VAL_EM;
      halt_q   <= 1'b1;
    end
  end

  assign HALT   = halt_q;
  assign TOHOST = tohost_q;
`else
  logic unused_addr_bits;

  assign mmio_hit         = 1'b0;
  assign mmio_rdata       = 32'h0;
  assign HALT             = 1'b0;
  assign TOHOST           = 32'h0;
  assign unused_addr_bits = ^{ALU_VAL_EM[31:AW+2], DMSE_EM & 1'b0};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus randomized
// traffic compared against a byte-array reference model.
module tb_dmem_responder;

  localparam int NBYTES = 4 * 4096;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [31:0] ALU_VAL_EM = '0;
  logic [31:0] STORE_VAL_EM = '0;
  logic [1:0]  MemWrite_EM = '0;
  logic [1:0]  MemRead_EM = '0;
  logic        DMSE_EM = 1'b0;
  logic [31:0] MEM_DATA_M;
  logic        MISALIGN;
  logic [31:0] ERR_ADDR;
  logic        HALT;
  logic [31:0] TOHOST;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem_m [NBYTES];
  bit          m_mis = 1'b0;
  logic [31:0] m_err = '0;
  bit          m_halt = 1'b0;
  logic [31:0] m_tohost = '0;
  logic [31:0] last_rd;

  dmem_responder dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .ALU_VAL_EM   (ALU_VAL_EM),
    .STORE_VAL_EM (STORE_VAL_EM),
    .MemWrite_EM  (MemWrite_EM),
    .MemRead_EM   (MemRead_EM),
    .DMSE_EM      (DMSE_EM),
    .MEM_DATA_M   (MEM_DATA_M),
    .MISALIGN     (MISALIGN),
    .ERR_ADDR     (ERR_ADDR),
    .HALT         (HALT),
    .TOHOST       (TOHOST)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] sz);
    return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : (sz == 2'd3) ? 4 : 0;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return (a >= 32'hFFFF_FF00) && (a <= 32'hFFFF_FF0F);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit mis_m(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 1'b0;
    if (in_mmio(a) && sz != 2'd3) return 1'b1;
    return (a % nb(sz)) != 0;
  endfunction

  function automatic logic [31:0] load_m(input logic [31:0] a, input logic [1:0] sz, input bit se);
    logic [31:0] v;
    int n;
    if (sz == 2'd0 || mis_m(a, sz)) return 32'h0;
    if (in_mmio(a)) return (a[3:0] == 4'h4) ? m_tohost : 32'h0;
    n = nb(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_m[(a + i) % NBYTES]) << (8 * i));
    if (se && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic commit_m(input logic [31:0] a, input logic [1:0] rd, input logic [1:0] wr,
                          input logic [31:0] d);
    if (mis_m(a, rd) || mis_m(a, wr)) begin
      if (!m_mis) m_err = a;
      m_mis = 1'b1;
    end else if (wr != 2'd0) begin
      if (in_mmio(a)) begin
        if (a[3:0] == 4'h4) begin
          m_tohost = d;
          m_halt   = 1'b1;
        end
      end else begin
        for (int i = 0; i < nb(wr); i++) mem_m[(a + i) % NBYTES] = d[8*i +: 8];
      end
    end
  endtask

  // One bus cycle: drive, check the load mid-cycle, let the edge commit.
  task automatic op(input logic [31:0] a, input logic [1:0] rd, input logic [1:0] wr,
                    input bit se, input logic [31:0] d, input string tag);
    logic [31:0] exp;
    ALU_VAL_EM   = a;
    MemRead_EM   = rd;
    MemWrite_EM  = wr;
    DMSE_EM      = se;
    STORE_VAL_EM = d;
    exp = load_m(a, rd, se);
    @(negedge CLK);
    last_rd = MEM_DATA_M;
    if (rd != 2'd0) chk(tag, MEM_DATA_M, exp);
    @(posedge CLK);
    commit_m(a, rd, wr, d);
    #1;
    MemRead_EM  = 2'd0;
    MemWrite_EM = 2'd0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_misalign"}, 32'(MISALIGN), 32'(m_mis));
    chk({tag, "_err_addr"}, ERR_ADDR, m_err);
    chk({tag, "_halt"},     32'(HALT),     32'(m_halt));
    chk({tag, "_tohost"},   TOHOST,   m_tohost);
  endtask

  initial begin
    logic [31:0] a, d, c0, c1;
    logic [1:0]  sz, rd, wr;
    int kind;

    #2;
    check_flags("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 256; i++) op(32'(i * 4), 2'd0, 2'd3, 1'b0, $urandom, "prefill");

    op(32'h100, 2'd0, 2'd3, 1'b0, 32'h8899_AABB, "st_w100");
    for (int i = 0; i < 4; i++) op(32'h100 + 32'(i), 2'd1, 2'd0, 1'b1, 32'h0, "lb_se");
    op(32'h103, 2'd1, 2'd0, 1'b1, 32'h0, "lb_se_103");
    chk("lb_se_103_const", last_rd, 32'hFFFF_FF88);
    for (int i = 0; i < 4; i++) op(32'h100 + 32'(i), 2'd1, 2'd0, 1'b0, 32'h0, "lb_ze");
    op(32'h101, 2'd1, 2'd0, 1'b0, 32'h0, "lb_ze_101");
    chk("lb_ze_101_const", last_rd, 32'h0000_00AA);
    op(32'h100, 2'd0, 2'd0, 1'b0, 32'h0, "no_read");
    chk("no_read_zero", last_rd, 32'h0);

    op(32'h200, 2'd0, 2'd3, 1'b0, 32'hDEAD_BEEF, "st_w200");
    op(32'h202, 2'd0, 2'd2, 1'b0, 32'h0000_1234, "st_h202");
    op(32'h200, 2'd3, 2'd0, 1'b0, 32'h0, "lw_200");
    chk("lw_200_const", last_rd, 32'h1234_BEEF);
    op(32'h202, 2'd2, 2'd0, 1'b1, 32'h0, "lh_202");
    chk("lh_202_const", last_rd, 32'h0000_1234);
    op(32'h200, 2'd2, 2'd0, 1'b1, 32'h0, "lh_200_se");
    chk("lh_200_se_const", last_rd, 32'hFFFF_BEEF);

    check_flags("pre_mis");
    op(32'h101, 2'd3, 2'd0, 1'b0, 32'h0, "lw_101_mis");
    chk("lw_101_zero", last_rd, 32'h0);
    check_flags("mis1");
    chk("mis1_err_const", ERR_ADDR, 32'h101);
    op(32'h203, 2'd0, 2'd2, 1'b0, 32'h0000_5555, "sh_203_mis");
    check_flags("mis2");
    op(32'h200, 2'd3, 2'd0, 1'b0, 32'h0, "lw_200_after");
    chk("lw_200_after_const", last_rd, 32'h1234_BEEF);

    op(32'h40, 2'd0, 2'd3, 1'b0, 32'hCAFE_F00D, "st_w40");
    op(32'h40, 2'd3, 2'd0, 1'b0, 32'h0, "b2b_lw40");
    chk("b2b_const", last_rd, 32'hCAFE_F00D);
    op(32'h0000_4100, 2'd3, 2'd0, 1'b0, 32'h0, "alias_4100");
    op(32'h40, 2'd3, 2'd3, 1'b0, 32'h1357_9BDF, "both_old");
    chk("both_old_const", last_rd, 32'hCAFE_F00D);
    op(32'h40, 2'd3, 2'd0, 1'b0, 32'h0, "both_new");

    op(32'hFFFF_FF04, 2'd0, 2'd3, 1'b0, 32'h0000_0001, "st_tohost");
    op(32'hFFFF_FF04, 2'd3, 2'd0, 1'b0, 32'h0, "ld_tohost");
    check_flags("tohost");
`ifdef DMEM_MMIO_EN
    chk("halt_const", 32'(HALT), 32'd1);
    chk("tohost_const", TOHOST, 32'd1);
    ALU_VAL_EM  = 32'hFFFF_FF00;
    MemRead_EM  = 2'd3;
    MemWrite_EM = 2'd0;
    @(negedge CLK);
    c0 = MEM_DATA_M;
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    c1 = MEM_DATA_M;
    chk("cycle_delta", c1 - c0, 32'd7);
    @(posedge CLK);
    #1;
    MemRead_EM = 2'd0;
`endif

    for (int i = 0; i < 300; i++) begin
      sz   = 2'($urandom_range(1, 3));
      a    = 32'($urandom_range(0, 1023)) & ~32'(nb(sz) - 1);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      a    = a | ($urandom & 32'h7FFF_C000);
      kind = $urandom_range(0, 9);
      rd   = (kind < 5 || kind == 9) ? sz : 2'd0;
      wr   = (kind >= 5) ? sz : 2'd0;
      d    = $urandom;
      op(a, rd, wr, 1'($urandom_range(0, 1)), d, "rand");
    end
    check_flags("rand");

    ALU_VAL_EM   = 32'h80;
    STORE_VAL_EM = 32'h5A5A_5A5A;
    MemWrite_EM  = 2'd3;
    MemRead_EM   = 2'd0;
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    m_mis = 1'b0;
    m_err = '0;
    m_halt = 1'b0;
    m_tohost = '0;
    check_flags("rst_mid");
    @(posedge CLK);
    #1;
    MemWrite_EM = 2'd0;
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    op(32'h80, 2'd3, 2'd0, 1'b0, 32'h0, "lw_80_after_rst");
    check_flags("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
